pe_lanes: RTL and testbench
===========================

# pe_lanes

Multi-lane processing element for the matrix multiplier: holds one row A[i,*] and computes LANES dot products C[i,j..j+LANES-1] in parallel from a stream of B column entries. It is the parametrised successor of the single-lane PE: a lane count, stall-tolerant valid/ready input stream, held results with output backpressure, and per-lane overflow detection with optional saturation. It sits between the B-column feeder and the result collector.

## Interface
- N, 8, dot-product length (beats per computation); N >= 2
- DATA_WIDTH, 16, signed element width
- ACCUM_WIDTH, 2*DATA_WIDTH, signed accumulator width; must be >= 2*DATA_WIDTH
- LANES, 4, parallel output columns; LANES >= 1

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- load_row  in  1  capture row[] into row buffer (accepted in IDLE only)
- row  in  N x DATA_WIDTH  A[i,0..N-1], signed
- start  in  1  begin one computation (accepted in IDLE only)
- col_valid  in  1  col_entry beat valid
- col_ready  out  1  PE accepts a beat
- col_entry  in  LANES x DATA_WIDTH  B[k, j+l] for lane l, signed
- res_valid  out  1  total[] valid and held
- res_ready  in  1  consumer accepts results
- total  out  LANES x ACCUM_WIDTH  per-lane dot product, signed
- err  out  LANES  per-lane overflow flag, valid with res_valid
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, COMPUTE, DONE.
- IDLE: col_ready=0, res_valid=0. load_row=1 copies row into buffer. start=1 -> clear all accumulators, err, k=0; go COMPUTE. If load_row and start in same cycle, buffer takes new row and computation uses it.
- COMPUTE: col_ready=1. Beat accepted when col_valid&col_ready: acc[l] <= acc[l] + sext(row_buf[k]*col_entry[l]); k++. Cycles with col_valid=0 are stalls: no state change. Acceptance of beat k=N-1 -> DONE.
- DONE: res_valid=1, total/err stable. res_ready=1 -> IDLE (same-cycle handoff; start in that cycle is ignored).
- start and load_row outside IDLE are ignored; row buffer never changes mid-computation.
- Arithmetic: full-precision signed product (2*DATA_WIDTH), sign-extended to ACCUM_WIDTH, signed add. Overflow = operands same sign, result sign differs. err[l] sticky from first overflow until next accepted start.
- total holds the last result in IDLE until next start clears it.
- k width = $clog2(N); k never exceeds N-1.

## Timing
- Reset: state IDLE, k=0, row buffer 0, accumulators 0, col_ready=0, res_valid=0, busy=0, total all 0, err all 0. Reset mid-COMPUTE or mid-DONE abandons the computation; result is not presented.
- start accepted at edge T -> col_ready=1 from cycle T+1.
- Last beat accepted at edge E -> res_valid=1 and final total from cycle E+1 (one-cycle latency, no sync state).
- Minimum computation: N+2 cycles start-to-IDLE with col_valid held high and res_ready high.
- res_valid held indefinitely while res_ready=0; total/err must not change.
- col_ready is a registered-state function only (no combinational path from col_valid or res_ready).

## Configuration
- PE_SATURATE_EN defined: on overflow, accumulator clamps to max positive (2^(ACCUM_WIDTH-1)-1) or min negative (-2^(ACCUM_WIDTH-1)) per direction of the overflow, and stays clamped through later beats unless a later add moves it back in range normally; err[l] set.
- Undefined: two's-complement wrap; err[l] still set.

## Test plan
- Basic (N=4, DW=8, AW=16, LANES=2): row=[1,2,3,4], lane0 cols=[1,1,1,1], lane1=[-1,0,2,5], col_valid always 1 -> res_valid at start+5, total=[10,25], err=00.
- Stalls: same data with col_valid low for 2 cycles between every beat -> identical totals, res_valid 6 cycles later than basic, k never advances on stalls.
- Backpressure: hold res_ready=0 for 3 cycles in DONE -> res_valid, total, err stable; start pulses during hold ignored; IDLE one cycle after res_ready=1.
- Overflow: row=[127]*4, lane0 cols=[127]*4 (16129 per beat) -> err[0]=1; with PE_SATURATE_EN total[0]=32767, without total[0]=-1020; lane1 zeros -> 0, err[1]=0.
- Reset mid-op: rst=1 after 2 beats -> next cycle all outputs at reset values, row buffer 0; new load/start with basic data yields [10,25].
- Row protection: load_row with [9,9,9,9] during COMPUTE -> ignored, basic totals unchanged.

Source files
------------

// File: rtl/pe_lanes.sv
// Multi-lane dot-product PE: holds one A row and accumulates LANES columns from a valid/ready B stream.
// Optional macro PE_SATURATE_EN: clamp accumulators on overflow instead of two's-complement wrap.
module pe_lanes #(
  parameter int N           = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int ACCUM_WIDTH = 2*DATA_WIDTH,
  parameter int LANES       = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  load_row,
  input  logic [N-1:0][DATA_WIDTH-1:0]          row,
  input  logic                                  start,
  input  logic                                  col_valid,
  output logic                                  col_ready,
  input  logic [LANES-1:0][DATA_WIDTH-1:0]      col_entry,
  output logic                                  res_valid,
  input  logic                                  res_ready,
  output logic [LANES-1:0][ACCUM_WIDTH-1:0]     total,
  output logic [LANES-1:0]                      err,
  output logic                                  busy
);

  localparam int PW = 2*DATA_WIDTH;
  localparam int KW = $clog2(N);
  localparam logic [KW-1:0] K_LAST = KW'(N-1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COMPUTE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

`ifdef PE_SATURATE_EN
  localparam logic [ACCUM_WIDTH-1:0] ACC_MAX = {1'b0, {(ACCUM_WIDTH-1){1'b1}}};
  localparam logic [ACCUM_WIDTH-1:0] ACC_MIN = {1'b1, {(ACCUM_WIDTH-1){1'b0}}};
`endif

  logic [1:0]                           state;
  logic [KW-1:0]                        k;
  logic [N-1:0][DATA_WIDTH-1:0]         row_buf;
  logic [LANES-1:0][ACCUM_WIDTH-1:0]    acc;

  logic signed [PW-1:0]                 a_x;
  logic signed [PW-1:0]                 b_x    [LANES];
  logic signed [PW-1:0]                 prod   [LANES];
  logic signed [ACCUM_WIDTH-1:0]        prod_x [LANES];
  logic [LANES-1:0][ACCUM_WIDTH-1:0]    sum;
  logic [LANES-1:0][ACCUM_WIDTH-1:0]    acc_next;
  logic [LANES-1:0]                     ovf;

  // NOTE: every signal written here gets a default first, so no path can leave it unassigned (no latch).
  always_comb begin
    a_x      = PW'($signed(row_buf[k]));
    sum      = '0;
    acc_next = '0;
    ovf      = '0;
    for (int l = 0; l < LANES; l++) begin
      b_x[l]    = PW'($signed(col_entry[l]));
      prod[l]   = a_x * b_x[l];
      prod_x[l] = ACCUM_WIDTH'(prod[l]);
      sum[l]    = acc[l] + prod_x[l];
      // Signed overflow: both addends share a sign the result does not.
      ovf[l]    = (acc[l][ACCUM_WIDTH-1] == prod_x[l][ACCUM_WIDTH-1]) &&
                  (sum[l][ACCUM_WIDTH-1] != acc[l][ACCUM_WIDTH-1]);
`ifdef PE_SATURATE_EN
      acc_next[l] = ovf[l] ? (acc[l][ACCUM_WIDTH-1] ? ACC_MIN : ACC_MAX) : sum[l];
`else
      acc_next[l] = sum[l];
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      k       <= '0;
      row_buf <= '0;
      acc     <= '0;
      err     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_row) row_buf <= row;
          if (start) begin
            acc   <= '0;
            err   <= '0;
            k     <= '0;
            state <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          if (col_valid) begin
            acc <= acc_next;
            err <= err | ovf;
            if (k == K_LAST) begin
              k     <= '0;
              state <= S_DONE;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake outputs decode registered state only.
  assign col_ready = (state == S_COMPUTE);
  assign res_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign total     = acc;

endmodule

// File: tb/tb_pe_lanes.sv
// Scoreboard bench for pe_lanes: driver pushes model results, a negedge monitor checks presented results.
// Honours PE_SATURATE_EN in its reference model.
module tb_pe_lanes;
  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int AW    = 16;
  localparam int LANES = 2;
  localparam longint AMAX = (64'sd1 <<< (AW-1)) - 1;
  localparam longint AMIN = -(64'sd1 <<< (AW-1));

  typedef logic signed [DW-1:0] elem_t;
  typedef struct {
    logic [LANES-1:0][AW-1:0] tot;
    logic [LANES-1:0]         err;
    int                       first_cyc;
  } exp_t;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         load_row;
  logic [N-1:0][DW-1:0]         row;
  logic                         start;
  logic                         col_valid;
  logic                         col_ready;
  logic [LANES-1:0][DW-1:0]     col_entry;
  logic                         res_valid;
  logic                         res_ready;
  logic [LANES-1:0][AW-1:0]     total;
  logic [LANES-1:0]             err;
  logic                         busy;

  pe_lanes #(.N(N), .DATA_WIDTH(DW), .ACCUM_WIDTH(AW), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .load_row(load_row), .row(row), .start(start),
    .col_valid(col_valid), .col_ready(col_ready), .col_entry(col_entry),
    .res_valid(res_valid), .res_ready(res_ready), .total(total), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    errors = 0;
  int    checks = 0;
  exp_t  sb[$];
  bit    seen_first = 1'b0;
  elem_t cur_row [N];
  elem_t cur_cols[N][LANES];
  elem_t buf_row [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: integer dot product with range test after each beat.
  function automatic exp_t model();
    exp_t e;
    for (int l = 0; l < LANES; l++) begin
      longint a = 0;
      bit     o = 1'b0;
      for (int i = 0; i < N; i++) begin
        a += longint'(buf_row[i]) * longint'(cur_cols[i][l]);
        if (a > AMAX || a < AMIN) begin
          o = 1'b1;
`ifdef PE_SATURATE_EN
          a = (a > AMAX) ? AMAX : AMIN;
`else
          a = (a > AMAX) ? a - (64'sd1 <<< AW) : a + (64'sd1 <<< AW);
`endif
        end
      end
      e.tot[l] = a[AW-1:0];
      e.err[l] = o;
    end
    e.first_cyc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      seen_first = 1'b0;
    end else if (res_valid) begin
      if (sb.size() == 0) begin
        check("res_valid_unexpected", 64'(res_valid), 64'd0);
      end else begin
        check("total", 64'(total), 64'(sb[0].tot));
        check("err", 64'(err), 64'(sb[0].err));
        if (!seen_first) begin
          check("res_latency_cycle", 64'(cyc), 64'(sb[0].first_cyc));
          seen_first = 1'b1;
        end
        if (res_ready) begin
          void'(sb.pop_front());
          seen_first = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_row_port();
    for (int i = 0; i < N; i++) row[i] = cur_row[i];
  endtask

  // One computation: optional row load, beats with `stall` idle cycles between them,
  // `hold` cycles of backpressure in DONE, optional ignored start/load_row traffic.
  task automatic run_txn(input int stall, input int hold, input bit do_load, input bit meddle);
    exp_t e;
    int   w;
    if (do_load) begin
      set_row_port();
      load_row = 1'b1;
      for (int i = 0; i < N; i++) buf_row[i] = cur_row[i];
    end
    start = 1'b1;
    e = model();
    e.first_cyc = cyc + 1 + N + stall*(N-1);
    sb.push_back(e);
    step();
    start = 1'b0;
    load_row = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    for (int b = 0; b < N; b++) begin
      if (b > 0) begin
        repeat (stall) begin
          col_valid = 1'b0;
          col_entry = LANES*DW'($urandom);
          step();
        end
      end
      col_valid = 1'b1;
      for (int l = 0; l < LANES; l++) col_entry[l] = cur_cols[b][l];
      if (meddle) begin
        load_row = 1'b1;
        start    = 1'b1;
        row      = N*DW'({$urandom, $urandom});
      end
      check("col_ready_in_compute", 64'(col_ready), 64'd1);
      step();
      load_row = 1'b0;
      start    = 1'b0;
    end
    col_valid = 1'b0;
    w = 0;
    while (!res_valid && w < 20) begin
      step();
      w++;
    end
    check("res_valid_reached", 64'(res_valid), 64'd1);
    repeat (hold) begin
      start    = 1'($urandom);
      load_row = 1'($urandom);
      row      = N*DW'({$urandom, $urandom});
      col_valid = 1'($urandom);
      step();
    end
    col_valid = 1'b0;
    res_ready = 1'b1;
    start     = 1'b1;
    step();
    res_ready = 1'b0;
    start     = 1'b0;
    load_row  = 1'b0;
    check("idle_after_handoff_busy", 64'(busy), 64'd0);
    check("idle_after_handoff_res_valid", 64'(res_valid), 64'd0);
    check("total_held_in_idle", 64'(total), 64'(e.tot));
  endtask

  task automatic set_basic();
    elem_t r [N] = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    elem_t c1[N] = '{-8'sd1, 8'sd0, 8'sd2, 8'sd5};
    for (int i = 0; i < N; i++) begin
      cur_row[i]     = r[i];
      cur_cols[i][0] = 8'sd1;
      cur_cols[i][1] = c1[i];
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_col_ready"}, 64'(col_ready), 64'd0);
    check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_total"}, 64'(total), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; load_row = 1'b0; start = 1'b0; col_valid = 1'b0;
    res_ready = 1'b0; row = '0; col_entry = '0;
    for (int i = 0; i < N; i++) buf_row[i] = '0;
    step();
    step();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Basic, then the same data with two stall cycles between beats.
    set_basic();
    run_txn(0, 0, 1'b1, 1'b0);
    run_txn(2, 0, 1'b0, 1'b0);
    // Backpressure with ignored start/load_row pulses, then row protection during compute.
    run_txn(0, 3, 1'b0, 1'b0);
    run_txn(1, 1, 1'b0, 1'b1);

    // Overflow on lane 0, lane 1 stays zero.
    for (int i = 0; i < N; i++) begin
      cur_row[i]     = 8'sd127;
      cur_cols[i][0] = 8'sd127;
      cur_cols[i][1] = 8'sd0;
    end
    run_txn(0, 2, 1'b1, 1'b0);

    // Reset after two accepted beats.
    set_basic();
    set_row_port();
    load_row = 1'b1;
    start    = 1'b1;
    step();
    load_row = 1'b0;
    start    = 1'b0;
    for (int b = 0; b < 2; b++) begin
      col_valid = 1'b1;
      for (int l = 0; l < LANES; l++) col_entry[l] = cur_cols[b][l];
      step();
    end
    col_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    for (int i = 0; i < N; i++) buf_row[i] = '0;
    check_reset_outputs("mid_op_reset");
    // Cleared row buffer yields zero totals; then basic data again.
    run_txn(0, 0, 1'b0, 1'b0);
    run_txn(0, 0, 1'b1, 1'b0);

    // Randomized traffic, biased toward extreme values to provoke overflow.
    for (int t = 0; t < 40; t++) begin
      bit ext = 1'($urandom);
      for (int i = 0; i < N; i++) begin
        cur_row[i] = ext ? (($urandom & 1) ? 8'sd127 : -8'sd128) : elem_t'($urandom);
        for (int l = 0; l < LANES; l++)
          cur_cols[i][l] = ext ? (($urandom & 1) ? 8'sd127 : -8'sd128) : elem_t'($urandom);
      end
      run_txn($urandom_range(0, 2), $urandom_range(0, 3), (t == 0) || 1'($urandom), 1'($urandom));
    end

    step();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
